prf_writeback_arbiter: RTL and testbench

//   Shares the physical register file's write ports between NUM_REQ writeback

---
 rtl/prf_writeback_arbiter.sv | 158 +++++++++++++++
 tb/tb_prf_writeback_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prf_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// prf_writeback_arbiter
//
// Shares the physical register file write ports between NUM_REQ writeback
// requesters using round-robin arbitration. Winners are registered and driven
// onto the regfile write ports one cycle after acceptance.
//
// Rules applied each cycle (wb_hold = 0):
//   - Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ.
//   - Requests to register 0 are accepted immediately and dropped. They use
//     no port and do not move rr_ptr.
//   - Other valid requests are granted in scan order until all ports are used.
//     A request whose select matches an earlier grant in the same cycle is
//     skipped and does not use a port.
//   - The k-th grant drives port k on the next cycle.
//   - rr_ptr moves to one past the last granted index.
// When wb_hold = 1, nothing is accepted and rr_ptr does not change.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        asynchronous reset, active-low
//   wb_hold    1 = grant nothing this cycle
//   req_valid  per-requester write pending
//   req_sel    per-requester destination register
//   req_val    per-requester write data
//   req_ready  per-requester accept (combinational, 0 while in reset)
//   w_enb      regfile write enable per port (registered)
//   w_sel      regfile write select per port (registered, holds when idle)
//   w_val      regfile write data per port (registered, holds when idle)
//   stall_cnt  saturating count of cycles in which a valid nonzero-select
//              request was left waiting
// -----------------------------------------------------------------------------
module prf_writeback_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int NUM_WRITE_PORT = 1,
  parameter int SELECT_WIDTH   = 6,
  parameter int DATA_WIDTH     = 32,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          wb_hold,
  input  logic [NUM_REQ-1:0]                            req_valid,
  input  logic [NUM_REQ-1:0][SELECT_WIDTH-1:0]          req_sel,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]            req_val,
  output logic [NUM_REQ-1:0]                            req_ready,
  output logic [NUM_WRITE_PORT-1:0]                     w_enb,
  output logic [NUM_WRITE_PORT-1:0][SELECT_WIDTH-1:0]   w_sel,
  output logic [NUM_WRITE_PORT-1:0][DATA_WIDTH-1:0]     w_val,
  output logic [CNT_WIDTH-1:0]                          stall_cnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]                           rr_ptr;
  logic [PTR_W-1:0]                           rr_next;
  logic [NUM_REQ-1:0]                         grant;
  logic [NUM_REQ-1:0]                         zero_ack;
  logic [NUM_WRITE_PORT-1:0]                  port_en;
  logic [NUM_WRITE_PORT-1:0][SELECT_WIDTH-1:0] port_sel;
  logic [NUM_WRITE_PORT-1:0][DATA_WIDTH-1:0]   port_val;
  logic                                       stall;

  // Arbitration. The outer loop walks scan positions. The inner loop picks the
  // requester at that position. Written this way, every array index is a loop
  // constant after unrolling.
  always_comb begin
    int  n_grant;
    int  idx;
    int  last_idx;
    logic conflict;

    // NOTE: every variable driven here gets a default before any conditional
    // assignment; a path that leaves one unassigned would infer a latch.
    grant    = '0;
    zero_ack = '0;
    port_en  = '0;
    port_sel = '0;
    port_val = '0;
    stall    = 1'b0;
    rr_next  = rr_ptr;
    n_grant  = 0;
    idx      = 0;
    last_idx = 0;
    conflict = 1'b0;

    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (j == idx && req_valid[j]) begin
          if (req_sel[j] == '0) begin
            // Register 0 is hard-wired: accept and drop, no port used.
            zero_ack[j] = !wb_hold;
          end else if (wb_hold) begin
            stall = 1'b1;
          end else begin
            conflict = 1'b0;
            for (int p = 0; p < NUM_WRITE_PORT; p++) begin
              if (p < n_grant && port_sel[p] == req_sel[j]) conflict = 1'b1;
            end
            if (conflict || n_grant >= NUM_WRITE_PORT) begin
              stall = 1'b1;
            end else begin
              grant[j] = 1'b1;
              for (int p = 0; p < NUM_WRITE_PORT; p++) begin
                if (p == n_grant) begin
                  port_en[p]  = 1'b1;
                  port_sel[p] = req_sel[j];
                  port_val[p] = req_val[j];
                end
              end
              n_grant  = n_grant + 1;
              last_idx = j;
            end
          end
        end
      end
    end

    if (n_grant > 0) begin
      rr_next = (last_idx == NUM_REQ - 1) ? '0 : PTR_W'(last_idx + 1);
    end
  end

  // Ready is combinational. It is forced low while reset is asserted so that no
  // handshake can complete while the output stage is being cleared.
  assign req_ready = (grant | zero_ack) & {NUM_REQ{rst}};

  // Output stage and arbitration state.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: only a few registers exist here, so all of them are reset,
      // including the select/data fields that w_enb qualifies.
      w_enb     <= '0;
      w_sel     <= '0;
      w_val     <= '0;
      rr_ptr    <= '0;
      stall_cnt <= '0;
    end else begin
      w_enb <= port_en;
      for (int p = 0; p < NUM_WRITE_PORT; p++) begin
        // Idle ports keep their last select/data values.
        if (port_en[p]) begin
          w_sel[p] <= port_sel[p];
          w_val[p] <= port_val[p];
        end
      end
      rr_ptr <= rr_next;
      if (stall && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_prf_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// tb_prf_writeback_arbiter
//
// Self-checking bench with two instances of the arbiter:
//   u0: NUM_WRITE_PORT=1, CNT_WIDTH=16
//   u1: NUM_WRITE_PORT=2, CNT_WIDTH=4
// Each instance has its own set of requesters. Those requesters keep a request
// stable until it is accepted. A reference model predicts:
//   - ready in the current cycle,
//   - the registered write ports,
//   - the stall counter.
// The model works from the arbitration rules using plain integer arithmetic.
// Directed scenarios run first, then a randomized phase.
// -----------------------------------------------------------------------------
module tb_prf_writeback_arbiter;

  localparam int NR = 4;
  localparam int SW = 6;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic wb_hold = 1'b0;

  always #5 clk = ~clk;

  // Requester-side stimulus, one set per instance.
  logic [NR-1:0]         d_valid [2];
  logic [NR-1:0][SW-1:0] d_sel   [2];
  logic [NR-1:0][DW-1:0] d_val   [2];

  logic [NR-1:0]         a_ready;
  logic [0:0]            a_enb;
  logic [0:0][SW-1:0]    a_sel;
  logic [0:0][DW-1:0]    a_val;
  logic [15:0]           a_cnt;

  logic [NR-1:0]         b_ready;
  logic [1:0]            b_enb;
  logic [1:0][SW-1:0]    b_sel;
  logic [1:0][DW-1:0]    b_val;
  logic [3:0]            b_cnt;

  prf_writeback_arbiter #(
    .NUM_REQ(NR), .NUM_WRITE_PORT(1), .SELECT_WIDTH(SW),
    .DATA_WIDTH(DW), .CNT_WIDTH(16)
  ) dut_a (
    .clk(clk), .rst(rst), .wb_hold(wb_hold),
    .req_valid(d_valid[0]), .req_sel(d_sel[0]), .req_val(d_val[0]),
    .req_ready(a_ready), .w_enb(a_enb), .w_sel(a_sel), .w_val(a_val),
    .stall_cnt(a_cnt)
  );

  prf_writeback_arbiter #(
    .NUM_REQ(NR), .NUM_WRITE_PORT(2), .SELECT_WIDTH(SW),
    .DATA_WIDTH(DW), .CNT_WIDTH(4)
  ) dut_b (
    .clk(clk), .rst(rst), .wb_hold(wb_hold),
    .req_valid(d_valid[1]), .req_sel(d_sel[1]), .req_val(d_val[1]),
    .req_ready(b_ready), .w_enb(b_enb), .w_sel(b_sel), .w_val(b_val),
    .stall_cnt(b_cnt)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [NR-1:0] obs_ready(input int u);
    return (u == 0) ? a_ready : b_ready;
  endfunction

  function automatic logic obs_enb(input int u, input int p);
    return (u == 0) ? a_enb[0] : b_enb[p[0]];
  endfunction

  function automatic logic [SW-1:0] obs_sel(input int u, input int p);
    return (u == 0) ? a_sel[0] : b_sel[p[0]];
  endfunction

  function automatic logic [DW-1:0] obs_val(input int u, input int p);
    return (u == 0) ? a_val[0] : b_val[p[0]];
  endfunction

  function automatic logic [15:0] obs_cnt(input int u);
    return (u == 0) ? a_cnt : {12'd0, b_cnt};
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int            m_ptr   [2];
  int            m_stall [2];
  logic          m_enb   [2][2];
  logic [SW-1:0] m_sel   [2][2];
  logic [DW-1:0] m_val   [2][2];

  logic [NR-1:0] exp_ready [2];
  int            g_idx     [2][2];
  int            g_cnt     [2];
  bit            stall_now [2];

  function automatic int nports(input int u);
    return (u == 0) ? 1 : 2;
  endfunction

  function automatic int cnt_max(input int u);
    return (u == 0) ? 65535 : 15;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_ptr[u]   = 0;
      m_stall[u] = 0;
      g_cnt[u]   = 0;
      for (int p = 0; p < 2; p++) begin
        m_enb[u][p] = 1'b0;
        m_sel[u][p] = '0;
        m_val[u][p] = '0;
      end
    end
  endtask

  // Decide this cycle's grants for instance u from its current requests.
  task automatic model_arb(input int u, input bit hold);
    int  i;
    bit  dup;
    exp_ready[u] = '0;
    g_cnt[u]     = 0;
    stall_now[u] = 1'b0;
    for (int k = 0; k < NR; k++) begin
      i = (m_ptr[u] + k) % NR;
      if (d_valid[u][i]) begin
        if (hold) begin
          if (d_sel[u][i] != 0) stall_now[u] = 1'b1;
        end else if (d_sel[u][i] == 0) begin
          exp_ready[u][i] = 1'b1;
        end else begin
          dup = 1'b0;
          for (int p = 0; p < g_cnt[u]; p++)
            if (d_sel[u][g_idx[u][p]] == d_sel[u][i]) dup = 1'b1;
          if (!dup && g_cnt[u] < nports(u)) begin
            exp_ready[u][i]     = 1'b1;
            g_idx[u][g_cnt[u]]  = i;
            g_cnt[u]            = g_cnt[u] + 1;
          end else begin
            stall_now[u] = 1'b1;
          end
        end
      end
    end
  endtask

  // Apply the clock edge to the model for instance u.
  task automatic model_commit(input int u);
    for (int p = 0; p < nports(u); p++) begin
      m_enb[u][p] = (p < g_cnt[u]);
      if (p < g_cnt[u]) begin
        m_sel[u][p] = d_sel[u][g_idx[u][p]];
        m_val[u][p] = d_val[u][g_idx[u][p]];
      end
    end
    if (g_cnt[u] > 0) m_ptr[u] = (g_idx[u][g_cnt[u]-1] + 1) % NR;
    if (stall_now[u] && m_stall[u] < cnt_max(u)) m_stall[u] = m_stall[u] + 1;
  endtask

  task automatic check_outputs(input int u);
    check($sformatf("u%0d req_ready", u), obs_ready(u), exp_ready[u]);
    for (int p = 0; p < nports(u); p++) begin
      check($sformatf("u%0d w_enb[%0d]", u, p), obs_enb(u, p), m_enb[u][p]);
      check($sformatf("u%0d w_sel[%0d]", u, p), obs_sel(u, p), m_sel[u][p]);
      check($sformatf("u%0d w_val[%0d]", u, p), obs_val(u, p), m_val[u][p]);
    end
    check($sformatf("u%0d stall_cnt", u), obs_cnt(u), 64'(m_stall[u]));
  endtask

  task automatic check_reset_state(input string tag);
    for (int u = 0; u < 2; u++) begin
      check($sformatf("%s u%0d ready", tag, u), obs_ready(u), 0);
      for (int p = 0; p < nports(u); p++) begin
        check($sformatf("%s u%0d w_enb[%0d]", tag, u, p), obs_enb(u, p), 0);
        check($sformatf("%s u%0d w_sel[%0d]", tag, u, p), obs_sel(u, p), 0);
        check($sformatf("%s u%0d w_val[%0d]", tag, u, p), obs_val(u, p), 0);
      end
      check($sformatf("%s u%0d stall_cnt", tag, u), obs_cnt(u), 0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic new_req(input int u, input int i);
    d_valid[u][i] = 1'b1;
    d_sel[u][i]   = SW'($urandom_range(0, 12));
    d_val[u][i]   = $urandom;
  endtask

  // Same request for requester i on both instances.
  task automatic set_req(input int i, input logic [SW-1:0] s,
                         input logic [DW-1:0] v);
    for (int u = 0; u < 2; u++) begin
      d_valid[u][i] = 1'b1;
      d_sel[u][i]   = s;
      d_val[u][i]   = v;
    end
  endtask

  // One clock cycle:
  //   - at the falling edge, predict ready and compare every output;
  //   - at the rising edge, advance the model;
  //   - just after the edge, update requesters (accepted requests retire or,
  //     in random mode, are replaced).
  task automatic cycle(input bit hold, input bit rnd);
    wb_hold = hold;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      model_arb(u, hold);
      check_outputs(u);
    end
    @(posedge clk);
    for (int u = 0; u < 2; u++) model_commit(u);
    #1;
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < NR; i++) begin
        if (exp_ready[u][i]) begin
          if (rnd && $urandom_range(0, 9) < 6) new_req(u, i);
          else d_valid[u][i] = 1'b0;
        end else if (rnd && !d_valid[u][i] && $urandom_range(0, 1) == 1) begin
          new_req(u, i);
        end
      end
    end
  endtask

  task automatic drain(input string tag, input int max_cycles);
    int n;
    n = 0;
    while ((|d_valid[0] || |d_valid[1]) && n < max_cycles) begin
      cycle(1'b0, 1'b0);
      n++;
    end
    check($sformatf("%s drain pending", tag), {d_valid[1], d_valid[0]}, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    for (int u = 0; u < 2; u++) begin
      d_valid[u] = '0;
      d_sel[u]   = '0;
      d_val[u]   = '0;
    end
    model_reset();
    #1;
    check_reset_state("por");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Four requesters with distinct selects; rr_ptr starts at 0.
    for (int i = 0; i < NR; i++) set_req(i, SW'(5 + i), $urandom);
    drain("order", 10);

    // Move rr_ptr to 1, then present a select conflict.
    set_req(0, 6'd10, 32'h1000_0000);
    drain("ptr1", 4);
    set_req(1, 6'd9, 32'h1111_1111);
    set_req(2, 6'd9, 32'h2222_2222);
    set_req(3, 6'd4, 32'h3333_3333);
    drain("conflict", 8);

    // A register-0 write is absorbed alongside a real write.
    set_req(0, 6'd0, 32'h0000_DEAD);
    set_req(1, 6'd3, 32'h0000_0333);
    drain("reg0", 4);

    // wb_hold for three cycles with one request pending.
    set_req(2, 6'd17, 32'hABCD_0002);
    repeat (3) cycle(1'b1, 1'b0);
    drain("hold", 4);

    // Reset asserted while a write is on the output ports.
    set_req(0, 6'd11, 32'hB000_0000);
    set_req(1, 6'd12, 32'hB000_0001);
    set_req(2, 6'd13, 32'hB000_0002);
    set_req(3, 6'd14, 32'hB000_0003);
    cycle(1'b0, 1'b0);
    check("pre-reset u0 w_enb", obs_enb(0, 0), 1);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_reset_state("async");
    @(negedge clk);
    check_reset_state("inrst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    drain("post-reset", 8);

    // Long hold with a pending request: the 4-bit counter must saturate.
    set_req(1, 6'd20, 32'h5555_AAAA);
    repeat (20) cycle(1'b1, 1'b0);
    check("u1 stall_cnt saturated", obs_cnt(1), 15);
    drain("sat", 4);

    // Randomized traffic.
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < NR; i++) new_req(u, i);
    repeat (1500) cycle($urandom_range(0, 99) < 15, 1'b1);
    drain("random", 32);
    repeat (2) cycle(1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
